// File: rtl/decode_pkg.sv
// decode_pkg: constants shared by the decode stage and its hazard unit.
//   - opcode encodings (NOP, LOAD)
//   - instruction field positions; positions that move with the parameter
//     set are exposed as small helper functions so every user slices the
//     instruction word the same way.
package decode_pkg;

  localparam logic [3:0] NOP_OP  = 4'h0;
  localparam logic [3:0] LOAD_OP = 4'h8;

  // rd and rs2 both sit at the bottom of the word
  localparam int RD_LSB  = 0;
  localparam int RS2_LSB = 0;

  // rs1 sits directly above rs2
  function automatic int rs1_lsb(input int reg_idx_w);
    return reg_idx_w;
  endfunction

  // immediate sits directly above rd (overlaps rs1 by design)
  function automatic int imm_lsb(input int reg_idx_w);
    return reg_idx_w;
  endfunction

  // opcode occupies the top OPC_W bits
  function automatic int opc_lsb(input int data_w, input int opc_w);
    return data_w - opc_w;
  endfunction

endpackage

// File: rtl/decode_stage_hazard_unit.sv
// decode_hazard_unit: load-use interlock and saturating stall counter.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid            fetch has an instruction pending
//   out_valid           decode output register holds an instruction
//   opcode_out, rd_out  instruction currently in the output register
//   rs1_idx, rs2_idx    source indices of the pending instruction
//   flush               squash; stall cycles under flush are not counted
//   hazard_stall        combinational interlock request
//   stall_cnt           saturating count of stall cycles
module decode_hazard_unit
  import decode_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 out_valid,
  input  logic [OPC_W-1:0]     opcode_out,
  input  logic [REG_IDX_W-1:0] rd_out,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic                 flush,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic rd_match;

  // r0 is never a real destination, so a load to r0 cannot create a hazard
  assign rd_match = (rd_out != '0) && ((rd_out == rs1_idx) || (rd_out == rs2_idx));

  assign hazard_stall = in_valid && out_valid &&
                        (opcode_out == OPC_W'(LOAD_OP)) && rd_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (hazard_stall && !flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-register decode pipeline stage.
// Slices the fetched instruction, reads the register file combinationally,
// and captures opcode / PC / operands / immediate / rd into one output
// register with a valid/ready handshake on both sides.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             fetch-side handshake
//   instr_in, next_pc_in          fetched instruction and PC+1
//   bp_taken                      predicted taken: current instr becomes NOP
//   flush                         squash output register and current input
//   rs1_idx/rs2_idx               regfile read indices (combinational)
//   rs1_data/rs2_data             regfile read data (same cycle)
//   target_addr                   zero-extended low field (combinational)
//   out_valid/out_ready           execute-side handshake
//   opcode_out, next_pc_out, rs1_data_out, rs2_data_out, imm_out, rd_out
//                                 registered decode results
//   hazard_stall, stall_cnt       load-use interlock and its stall count
// Configuration: define DECODE_HAZARD_EN to build the load-use interlock;
// without it hazard_stall and stall_cnt are constant zero.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OPC_W     = 4,
  parameter int REG_IDX_W = 5,
  parameter int IMM_W     = 7,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    instr_in,
  input  logic [DATA_W-1:0]    next_pc_in,
  input  logic                 bp_taken,
  input  logic                 flush,
  output logic [REG_IDX_W-1:0] rs1_idx,
  output logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [DATA_W-1:0]    rs1_data,
  input  logic [DATA_W-1:0]    rs2_data,
  output logic [DATA_W-1:0]    target_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPC_W-1:0]     opcode_out,
  output logic [DATA_W-1:0]    next_pc_out,
  output logic [DATA_W-1:0]    rs1_data_out,
  output logic [DATA_W-1:0]    rs2_data_out,
  output logic [DATA_W-1:0]    imm_out,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int OPC_LSB = opc_lsb(DATA_W, OPC_W);
  localparam int RS1_LSB = rs1_lsb(REG_IDX_W);
  localparam int IMM_LSB = imm_lsb(REG_IDX_W);

  typedef struct packed {
    logic [OPC_W-1:0]     opc;
    logic [DATA_W-1:0]    npc;
    logic [DATA_W-1:0]    rs1;
    logic [DATA_W-1:0]    rs2;
    logic [DATA_W-1:0]    imm;
    logic [REG_IDX_W-1:0] rd;
  } dec_out_t;

  dec_out_t         out_d, out_q;
  logic             vld_q;
  logic             capture;
  logic [IMM_W-1:0] imm_raw;

  // ---- combinational field extraction ----
  assign rs1_idx     = instr_in[RS1_LSB +: REG_IDX_W];
  assign rs2_idx     = instr_in[RS2_LSB +: REG_IDX_W];
  assign target_addr = DATA_W'(instr_in[OPC_LSB-1:0]);
  assign imm_raw     = instr_in[IMM_LSB +: IMM_W];

  always_comb begin
    out_d     = '0;
    // a predicted-taken branch squashes only the opcode; the rest of the
    // fields still flow so downstream debug sees what was fetched
    out_d.opc = bp_taken ? OPC_W'(NOP_OP) : instr_in[OPC_LSB +: OPC_W];
    out_d.npc = next_pc_in;
    out_d.rs1 = rs1_data;
    out_d.rs2 = rs2_data;
    out_d.imm = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
    out_d.rd  = instr_in[RD_LSB +: REG_IDX_W];
  end

  // ---- handshake ----
  assign in_ready = (!vld_q || out_ready) && !hazard_stall && !flush;
  assign capture  = in_valid && in_ready;

  // ---- output register ----
  // flush has priority over everything; capture implies !flush already,
  // but keeping the branch first makes the priority explicit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      out_q     <= '0;
      out_q.opc <= OPC_W'(NOP_OP);
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (capture) begin
      vld_q <= 1'b1;
      out_q <= out_d;
    end else if (vld_q && out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid    = vld_q;
  assign opcode_out   = out_q.opc;
  assign next_pc_out  = out_q.npc;
  assign rs1_data_out = out_q.rs1;
  assign rs2_data_out = out_q.rs2;
  assign imm_out      = out_q.imm;
  assign rd_out       = out_q.rd;

  // ---- load-use interlock ----
`ifdef DECODE_HAZARD_EN
  decode_hazard_unit #(
    .OPC_W     (OPC_W),
    .REG_IDX_W (REG_IDX_W),
    .CNT_W     (CNT_W)
  ) u_hazard (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .out_valid    (vld_q),
    .opcode_out   (out_q.opc),
    .rd_out       (out_q.rd),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .stall_cnt    (stall_cnt)
  );
`else
  assign hazard_stall = 1'b0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam int CW = 3;
`ifdef DECODE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [15:0]   instr_in, next_pc_in;
  logic          bp_taken, flush;
  logic [4:0]    rs1_idx, rs2_idx;
  logic [15:0]   rs1_data, rs2_data, target_addr;
  logic          out_valid, out_ready;
  logic [3:0]    opcode_out;
  logic [15:0]   next_pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]    rd_out;
  logic          hazard_stall;
  logic [CW-1:0] stall_cnt;

  decode_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .next_pc_in(next_pc_in), .bp_taken(bp_taken),
    .flush(flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .target_addr(target_addr),
    .out_valid(out_valid), .out_ready(out_ready), .opcode_out(opcode_out),
    .next_pc_out(next_pc_out), .rs1_data_out(rs1_data_out),
    .rs2_data_out(rs2_data_out), .imm_out(imm_out), .rd_out(rd_out),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] npc, r1, r2, imm;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [15:0] instr, npc;
    logic        bp;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic [15:0] imm;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[6];
  logic [CW-1:0] m_cnt;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, check against model, advance model at posedge
  task automatic step(input logic iv, input logic [15:0] ins, input logic [15:0] npc,
                      input logic bp, input logic fl, input logic ordy);
    logic ev, eh, er;
    logic [15:0] d1, d2;
    exp_t e;
    @(negedge clk);
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    in_valid = iv; instr_in = ins; next_pc_in = npc; bp_taken = bp;
    flush = fl; out_ready = ordy; rs1_data = d1; rs2_data = d2;
    #1;
    ev = (sb.size() != 0);
    eh = HZ && iv && ev && (sb[0].opc == 4'h8) && (sb[0].rd != 5'd0) &&
         ((sb[0].rd == ins[9:5]) || (sb[0].rd == ins[4:0]));
    er = (!ev || ordy) && !eh && !fl;
    chk("out_valid", 16'(out_valid), 16'(ev));
    if (ev) begin
      chk("opcode_out", 16'(opcode_out), 16'(sb[0].opc));
      chk("next_pc_out", next_pc_out, sb[0].npc);
      chk("rs1_data_out", rs1_data_out, sb[0].r1);
      chk("rs2_data_out", rs2_data_out, sb[0].r2);
      chk("imm_out", imm_out, sb[0].imm);
      chk("rd_out", 16'(rd_out), 16'(sb[0].rd));
    end
    chk("in_ready", 16'(in_ready), 16'(er));
    chk("hazard_stall", 16'(hazard_stall), 16'(eh));
    chk("stall_cnt", 16'(stall_cnt), 16'(m_cnt));
    chk("rs1_idx", 16'(rs1_idx), 16'(ins[9:5]));
    chk("rs2_idx", 16'(rs2_idx), 16'(ins[4:0]));
    chk("target_addr", target_addr, {4'h0, ins[11:0]});
    @(posedge clk);
    if (eh && !fl && (m_cnt != '1)) m_cnt++;
    if (fl) sb.delete();
    else begin
      if (ev && ordy) void'(sb.pop_front());
      if (iv && er) begin
        e.opc = bp ? 4'h0 : ins[15:12];
        e.npc = npc; e.r1 = d1; e.r2 = d2;
        e.imm = {{9{ins[11]}}, ins[11:5]};
        e.rd  = ins[4:0];
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, ordy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 16'(out_valid), 16'h0);
    chk({tag, "_opcode"}, 16'(opcode_out), 16'h0);
    chk({tag, "_npc"}, next_pc_out, 16'h0);
    chk({tag, "_rs1d"}, rs1_data_out, 16'h0);
    chk({tag, "_rs2d"}, rs2_data_out, 16'h0);
    chk({tag, "_imm"}, imm_out, 16'h0);
    chk({tag, "_rd"}, 16'(rd_out), 16'h0);
    chk({tag, "_stall_cnt"}, 16'(stall_cnt), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'h8123, 16'h0005, 1'b0, 4'h8, 5'h03, 16'h0009};
    tbl[1] = '{16'h3ABC, 16'h0011, 1'b1, 4'h0, 5'h1C, 16'hFFD5};
    tbl[2] = '{16'h3ABC, 16'h0012, 1'b0, 4'h3, 5'h1C, 16'hFFD5};
    tbl[3] = '{16'hF000, 16'hFFFF, 1'b0, 4'hF, 5'h00, 16'h0000};
    tbl[4] = '{16'h0FE0, 16'h1234, 1'b0, 4'h0, 5'h00, 16'hFFFF};
    tbl[5] = '{16'h07E1, 16'h8000, 1'b0, 4'h0, 5'h01, 16'h003F};

    m_cnt = '0;
    rst = 1'b1; in_valid = 1'b0; instr_in = '0; next_pc_in = '0;
    bp_taken = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rs1_data = '0; rs2_data = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // table vectors: capture, then check the registered fields one cycle later
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].instr, tbl[i].npc, tbl[i].bp, 1'b0, 1'b1);
      #1;
      chk("tbl_out_valid", 16'(out_valid), 16'h1);
      chk("tbl_opcode", 16'(opcode_out), 16'(tbl[i].opc));
      chk("tbl_rd", 16'(rd_out), 16'(tbl[i].rd));
      chk("tbl_imm", imm_out, tbl[i].imm);
      chk("tbl_npc", next_pc_out, tbl[i].npc);
      idle(1'b1);
    end
    idle(1'b1);

    // load r3 followed by a consumer of r3: one bubble
    step(1'b1, 16'h8123, 16'h0020, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h1067, 16'h0021, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h1067, 16'h0021, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    #1;
    chk("hazard_stall_cnt", 16'(stall_cnt), HZ ? 16'h1 : 16'h0);
    idle(1'b1);

    // backpressure: held output stable for three cycles
    step(1'b1, 16'h3ABC, 16'h0030, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h2222, 16'h0031, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 16'h0031, 1'b0, 1'b0, 1'b1);
    #1;
    chk("bp_release_opc", 16'(opcode_out), 16'h2);
    idle(1'b1);

    // flush with a valid output and a pending input
    step(1'b1, 16'h5555, 16'h0040, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h6666, 16'h0041, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_out_valid", 16'(out_valid), 16'h0);
    idle(1'b1);

    // sustained stall with out_ready low: counter saturates
    step(1'b1, 16'h8123, 16'h0050, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h1067, 16'h0051, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1067, 16'h0051, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h1067, 16'h0051, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    #1;
    chk("stall_cnt_sat", 16'(stall_cnt), HZ ? 16'h7 : 16'h0);

    // reset pulse in the middle of a stall
    step(1'b1, 16'h8123, 16'h0060, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; instr_in = 16'h1067; out_ready = 1'b0; rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    chk("rst_mid_hazard", 16'(hazard_stall), 16'h0);
    sb.delete();
    m_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    idle(1'b1);
    step(1'b1, 16'h4321, 16'h0070, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
